ibex_lsu_resp_unit: RTL
=======================

IBEX_LSU_RESP_UNIT -- requirements
Module: ibex_lsu_resp_unit

Interface
REQ-001 Parameter ResetAll, 1'b0: when 1, the held-data and request-attribute registers also reset asynchronously.
REQ-002 clk_i  input  1  single clock, all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 req_issue_i  input  1  data request granted this cycle; capture attributes.
REQ-005 req_we_i  input  1  1 = store, 0 = load.
REQ-006 req_type_i  input  2  ls_type_e: LS_WORD / LS_HALF / LS_BYTE.
REQ-007 req_sign_ext_i  input  1  sign-extend load result.
REQ-008 req_offset_i  input  2  byte offset within the first aligned word.
REQ-009 req_split_i  input  1  misaligned access needing two aligned beats.
REQ-010 ready_o  output  1  may accept req_issue_i.
REQ-011 data_rvalid_i  input  1  memory response beat valid.
REQ-012 data_rdata_i  input  32  response read data.
REQ-013 data_err_i  input  1  response bus error.
REQ-014 rf_wdata_lsu_o  output  32  aligned, extended load data.
REQ-015 rf_we_lsu_o  output  1  write the load result to the RF.
REQ-016 lsu_resp_valid_o  output  1  transaction complete (final beat).
REQ-017 lsu_resp_err_o  output  1  transaction completed with an error.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT_FIRST and WAIT_SECOND; ready_o = (state == IDLE).
REQ-019 IDLE + req_issue_i -> WAIT_FIRST; the block SHALL capture we/type/sign_ext/offset/split.
REQ-020 While ready_o=0, req_issue_i SHALL be ignored (no capture, no state change).
REQ-021 WAIT_FIRST + rvalid, split=0 -> IDLE; WAIT_FIRST + rvalid, split=1 -> WAIT_SECOND, latching data_rdata_i and data_err_i into first_q/err_q.
REQ-022 WAIT_SECOND + rvalid -> IDLE.
REQ-023 Outputs SHALL be combinational in the final-beat cycle, with zero latency: lsu_resp_valid_o = final beat rvalid.
REQ-024 Non-split data: byte = rdata[8*off+:8]; half = rdata[8*off+:16] (off in {0,2}, or off=1).
REQ-025 Split word, offset k in 1..3: data = {second[8k-1:0], first[31:8k]}.
REQ-026 Split half, offset 3: data = {second[7:0], first[31:24]}.
REQ-027 Byte/half results SHALL be zero-extended, or sign-extended from bit 7/15 when sign_ext=1.
REQ-028 lsu_resp_err_o = final-beat data_err_i OR err_q (an error on the first beat is still reported only at the second beat).
REQ-029 rf_we_lsu_o = lsu_resp_valid_o & ~we & ~lsu_resp_err_o; a store never writes the RF.
REQ-030 rf_wdata_lsu_o SHALL be 0 whenever rf_we_lsu_o=0.
REQ-031 data_rvalid_i in IDLE SHALL be ignored (no outputs asserted).
REQ-032 A final-beat rvalid and req_issue_i in the same cycle: the new issue is ignored (ready_o still 0 that cycle).

Reset
REQ-033 rst_ni low SHALL force IDLE and clear err_q, mid-transaction included; pending beats are abandoned.
REQ-034 Reset output values SHALL be: ready_o=1; lsu_resp_valid_o, lsu_resp_err_o and rf_we_lsu_o = 0; rf_wdata_lsu_o = 0.

Configuration
REQ-035 Macro IBEX_LSU_MISALIGNED_EN, when defined: split transactions behave per REQ-021..REQ-026.
REQ-036 When IBEX_LSU_MISALIGNED_EN is undefined: WAIT_SECOND and first_q are removed, and a split request completes on its first beat with lsu_resp_err_o=1 and rf_we_lsu_o=0.

Structure
REQ-037 ls_type_e SHALL reside in ibex_pkg; the FSM state enum SHALL be local to the module.
REQ-038 The alignment/extension logic SHALL be a combinational sub-module, ibex_load_data_extend (inputs: first, second, type, offset, split, sign_ext).

Verification
REQ-039 Word load, off 0, rdata 0xDEADBEEF -> valid=1, we=1, wdata 0xDEADBEEF, same cycle.
REQ-040 Byte load, off 2, sign_ext=1, rdata 0x0080_0000 -> wdata 0xFFFFFF80; with sign_ext=0 -> 0x00000080.
REQ-041 Split word, off 1, beats 0x44332211 then 0x88776655 -> no output after beat 1, then wdata 0x55443322 after beat 2.
REQ-042 Split half, off 3, beat 1 err=1, beat 2 err=0 -> beat 2: valid=1, err=1, we=0, wdata 0.
REQ-043 Store + rvalid -> valid=1, we=0; a req_issue_i while in WAIT_FIRST is ignored, and the response is attributed to the original request.
REQ-044 rst_ni pulsed low in WAIT_SECOND -> ready_o=1 immediately, and a following rvalid produces no output.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared LSU types: load/store access width and the attributes captured
// when a data request is granted.
package ibex_pkg;

  typedef enum logic [1:0] {
    LS_WORD = 2'b00,
    LS_HALF = 2'b01,
    LS_BYTE = 2'b10
  } ls_type_e;

  typedef struct packed {
    logic       we;
    ls_type_e   ls_type;
    logic       sign_ext;
    logic [1:0] offset;
    logic       split;
  } lsu_req_attr_t;

  localparam lsu_req_attr_t LSU_REQ_ATTR_RESET = '{
    we:       1'b0,
    ls_type:  LS_WORD,
    sign_ext: 1'b0,
    offset:   2'b00,
    split:    1'b0
  };

endpackage

// File: rtl/ibex_load_data_extend.sv
// Combinational load-data aligner: picks the addressed bytes out of one or two
// aligned response words and zero- or sign-extends them to 32 bits.
module ibex_load_data_extend
  import ibex_pkg::*;
(
  input  logic [31:0] first,
  input  logic [31:0] second,
  input  ls_type_e    ls_type,
  input  logic [1:0]  offset,
  input  logic        split,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [31:0] aligned;

  // A split access takes the upper bytes of the first beat as its low bytes and
  // fills the rest from the bottom of the second beat.
  always_comb begin
    aligned = first;
    if (split) begin
      case (offset)
        2'd1:    aligned = {second[7:0],  first[31:8]};
        2'd2:    aligned = {second[15:0], first[31:16]};
        2'd3:    aligned = {second[23:0], first[31:24]};
        default: aligned = first;
      endcase
    end else begin
      case (offset)
        2'd1:    aligned = {8'h00,  first[31:8]};
        2'd2:    aligned = {16'h0000, first[31:16]};
        2'd3:    aligned = {24'h000000, first[31:24]};
        default: aligned = first;
      endcase
    end
  end

  always_comb begin
    data = aligned;
    case (ls_type)
      LS_HALF: data = {{16{sign_ext & aligned[15]}}, aligned[15:0]};
      LS_BYTE: data = {{24{sign_ext & aligned[7]}}, aligned[7:0]};
      default: data = aligned;
    endcase
  end

endmodule

// File: rtl/ibex_lsu_resp_unit.sv
// Tracks one outstanding LSU data request and turns its response beat(s) into a
// register-file write. Define IBEX_LSU_MISALIGNED_EN for two-beat misaligned accesses.
module ibex_lsu_resp_unit
  import ibex_pkg::*;
#(
  parameter bit ResetAll = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_issue_i,
  input  logic        req_we_i,
  input  ls_type_e    req_type_i,
  input  logic        req_sign_ext_i,
  input  logic [1:0]  req_offset_i,
  input  logic        req_split_i,
  output logic        ready_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        rf_we_lsu_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o
);

  // Handshake: a request is accepted only in a cycle with req_issue_i && ready_o;
  // ready_o stays low until the final response beat has been seen, response beats
  // are consumed only while a request is outstanding, and lsu_resp_valid_o is a
  // single-cycle pulse in the same cycle as the final beat.
`ifdef IBEX_LSU_MISALIGNED_EN
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_FIRST  = 2'd1,
    WAIT_SECOND = 2'd2
  } resp_state_e;
`else
  typedef enum logic {
    IDLE       = 1'b0,
    WAIT_FIRST = 1'b1
  } resp_state_e;
`endif

  resp_state_e   state_q;
  lsu_req_attr_t attr_q, attr_d;
  logic          final_beat;
  logic          resp_err;
  logic [31:0]   ext_first, ext_second, ext_data;
  logic          ext_split;

  assign ready_o = (state_q == IDLE);

  always_comb begin
    attr_d = attr_q;
    if (ready_o && req_issue_i) begin
      attr_d.we       = req_we_i;
      attr_d.ls_type  = req_type_i;
      attr_d.sign_ext = req_sign_ext_i;
      attr_d.offset   = req_offset_i;
      attr_d.split    = req_split_i;
    end
  end

  if (ResetAll) begin : g_attr_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        attr_q <= LSU_REQ_ATTR_RESET;
      end else begin
        attr_q <= attr_d;
      end
    end
  end else begin : g_attr_norst
    always_ff @(posedge clk_i) begin
      attr_q <= attr_d;
    end
  end

`ifdef IBEX_LSU_MISALIGNED_EN
  logic        err_q;
  logic [31:0] first_q, first_d;

  assign final_beat = data_rvalid_i &
                      (((state_q == WAIT_FIRST) & ~attr_q.split) | (state_q == WAIT_SECOND));
  // A first-beat error is held and only reported alongside the second beat.
  assign resp_err   = data_err_i | err_q;
  assign first_d    = (state_q == WAIT_FIRST && data_rvalid_i && attr_q.split) ?
                      data_rdata_i : first_q;
  assign ext_first  = (state_q == WAIT_SECOND) ? first_q : data_rdata_i;
  assign ext_second = data_rdata_i;
  assign ext_split  = attr_q.split;

  if (ResetAll) begin : g_first_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        first_q <= 32'h0;
      end else begin
        first_q <= first_d;
      end
    end
  end else begin : g_first_norst
    always_ff @(posedge clk_i) begin
      first_q <= first_d;
    end
  end
`else
  assign final_beat = data_rvalid_i & (state_q == WAIT_FIRST);
  // Without misaligned support a split request is rejected on its only beat.
  assign resp_err   = data_err_i | attr_q.split;
  assign ext_first  = data_rdata_i;
  assign ext_second = 32'h0;
  assign ext_split  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
`ifdef IBEX_LSU_MISALIGNED_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_issue_i) begin
            state_q <= WAIT_FIRST;
`ifdef IBEX_LSU_MISALIGNED_EN
            err_q   <= 1'b0;
`endif
          end
        end
        WAIT_FIRST: begin
          if (data_rvalid_i) begin
`ifdef IBEX_LSU_MISALIGNED_EN
            if (attr_q.split) begin
              state_q <= WAIT_SECOND;
              err_q   <= data_err_i;
            end else begin
              state_q <= IDLE;
            end
`else
            state_q <= IDLE;
`endif
          end
        end
`ifdef IBEX_LSU_MISALIGNED_EN
        WAIT_SECOND: begin
          if (data_rvalid_i) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  ibex_load_data_extend u_load_data_extend (
    .first    (ext_first),
    .second   (ext_second),
    .ls_type  (attr_q.ls_type),
    .offset   (attr_q.offset),
    .split    (ext_split),
    .sign_ext (attr_q.sign_ext),
    .data     (ext_data)
  );

  assign lsu_resp_valid_o = final_beat;
  assign lsu_resp_err_o   = final_beat & resp_err;
  assign rf_we_lsu_o      = final_beat & ~attr_q.we & ~resp_err;
  assign rf_wdata_lsu_o   = rf_we_lsu_o ? ext_data : 32'h0;

endmodule
